// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the two CPU requesters, the shared memory port and the arbiter.
// The slave modport is the arbiter's view; master is the environment (CPU + memory).
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_busywait;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [2:0]            d_func3;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_busywait;
  logic                  cpu_busywait;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_busywait;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_func3, mem_rdata, mem_busywait,
    output i_rdata, i_busywait, d_rdata, d_busywait, cpu_busywait,
           mem_read, mem_write, mem_address, mem_wdata, mem_func3
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_func3, mem_rdata, mem_busywait,
    input  i_rdata, i_busywait, d_rdata, d_busywait, cpu_busywait,
           mem_read, mem_write, mem_address, mem_wdata, mem_func3
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the I-fetch and D (EX_MEM) ports onto one memory port, one transaction at a time,
// with a bounded D-streak so a stream of loads/stores cannot starve instruction fetch.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, I_ACC, D_ACC, I_RSP, D_RSP} state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t                state, state_nxt;
  logic [3:0]            streak;
  logic                  mem_read, mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_WIDTH-1:0] i_rdata, d_rdata;
  logic                  d_req, d_grant, i_grant, i_done, d_done;

  assign d_req   = bus.d_read | bus.d_write;
  assign d_grant = (state == IDLE) && d_req && (!bus.i_read || (streak < MAX_S));
  assign i_grant = (state == IDLE) && !d_grant && bus.i_read;
  assign i_done  = (state == I_ACC) && !bus.mem_busywait;
  assign d_done  = (state == D_ACC) && !bus.mem_busywait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (d_grant) state_nxt = D_ACC;
             else if (i_grant) state_nxt = I_ACC;
      I_ACC: if (!bus.mem_busywait) state_nxt = I_RSP;
      D_ACC: if (!bus.mem_busywait) state_nxt = D_RSP;
      I_RSP, D_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered: raised at grant, dropped at the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak      <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_func3   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      if (d_grant) begin
        mem_address <= bus.d_addr;
        mem_wdata   <= bus.d_wdata;
        mem_func3   <= bus.d_func3;
        mem_write   <= bus.d_write;
        mem_read    <= !bus.d_write;
        streak      <= !bus.i_read ? 4'd0 : (streak == MAX_S) ? streak : streak + 4'd1;
      end else if (i_grant) begin
        mem_address <= bus.i_addr;
        mem_wdata   <= '0;
        mem_func3   <= 3'b010;
        mem_write   <= 1'b0;
        mem_read    <= 1'b1;
        streak      <= '0;
      end
      if (i_done) begin
        i_rdata  <= bus.mem_rdata;
        mem_read <= 1'b0;
      end
      if (d_done) begin
        if (mem_read) d_rdata <= bus.mem_rdata;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

  assign bus.i_busywait   = bus.i_read & (state != I_RSP);
  assign bus.d_busywait   = d_req & (state != D_RSP);
  assign bus.cpu_busywait = bus.i_busywait | bus.d_busywait;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_address  = mem_address;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.mem_func3    = mem_func3;
  assign bus.i_rdata      = i_rdata;
  assign bus.d_rdata      = d_rdata;
endmodule
